// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder_scan block: state encoding, default
// parameter values and a constant-width helper.
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam int DEF_OUTS  = 8;
    localparam int DEF_DWELL = 4;

    // Bits needed to index n items; never less than 1 so ports stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/decoder_scan_if.sv
// Handshake and select bus of decoder_scan; master drives index/control,
// slave (the decoder) returns ready, the select vector and status.
interface decoder_scan_if
    import decoder_pkg::*;
#(
    parameter int OUTS = DEF_OUTS,
    parameter int W    = clog2(OUTS)
);
    logic            en;
    logic            mode;
    logic [W-1:0]    in;
    logic            in_valid;
    logic            in_ready;
    logic [OUTS-1:0] out;
    logic [W-1:0]    idx;
    logic            scan_wrap;
    logic            err;

    modport master (
        output en, mode, in, in_valid,
        input  in_ready, out, idx, scan_wrap, err
    );

    modport slave (
        input  en, mode, in, in_valid,
        output in_ready, out, idx, scan_wrap, err
    );
endinterface

// File: rtl/decoder_scan_onehot_dec.sv
// Combinational index-to-one-hot map; indices at or beyond OUTS give all zeros.
module onehot_dec
    import decoder_pkg::*;
#(
    parameter int W    = 3,
    parameter int OUTS = 8
) (
    input  logic [W-1:0]    idx_i,
    output logic [OUTS-1:0] onehot_o
);
    for (genvar gi = 0; gi < OUTS; gi++) begin : g_bit
        assign onehot_o[gi] = (idx_i == W'(gi));
    end
endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with direct (valid/ready) and auto-scan modes.
// Define DECODER_SCAN_ACTIVE_LOW_EN to make the select output active-low.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int OUTS  = DEF_OUTS,
    parameter int W     = clog2(OUTS),
    parameter int DWELL = DEF_DWELL
) (
    input  logic          clk,
    input  logic          rst_n,
    decoder_scan_if.slave bus
);
    localparam int              CW       = clog2(DWELL);
    localparam logic [W-1:0]    LAST_IDX = W'(OUTS - 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    localparam logic [OUTS-1:0] OUT_POL  = '1;
`else
    localparam logic [OUTS-1:0] OUT_POL  = '0;
`endif

    state_t          state_q;
    logic [W-1:0]    sel_q;
    logic [W-1:0]    idx_q;
    logic [CW-1:0]   cnt_q;
    logic [OUTS-1:0] out_q;
    logic            wrap_q;
    logic            err_q;

    logic            ready;
    logic            xfer;
    logic            in_oor;
    logic [W-1:0]    sel_d;
    logic [W-1:0]    idx_d;
    logic [CW-1:0]   cnt_d;
    logic            wrap_d;
    logic [W-1:0]    dec_idx;
    logic [OUTS-1:0] dec_out;

    always_comb begin
        ready  = (state_q != ST_SCAN);
        xfer   = bus.in_valid && ready;
        in_oor = (int'(bus.in) >= OUTS);
        sel_d  = xfer ? bus.in : sel_q;

        cnt_d  = cnt_q + CW'(1);
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (cnt_q == LAST_CNT) begin
            cnt_d  = '0;
            wrap_d = (idx_q == LAST_IDX);
            idx_d  = wrap_d ? '0 : idx_q + W'(1);
        end

        // Scan entry always restarts at index 0; direct shows the freshest selection.
        if (bus.mode) begin
            dec_idx = (state_q == ST_SCAN) ? idx_d : '0;
        end else begin
            dec_idx = sel_d;
        end
    end

    onehot_dec #(
        .W    (W),
        .OUTS (OUTS)
    ) u_dec (
        .idx_i    (dec_idx),
        .onehot_o (dec_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (xfer) begin
                sel_q <= bus.in;
                if (in_oor) begin
                    err_q <= 1'b1;
                end
            end
            wrap_q <= 1'b0;

            if (!bus.en) begin
                state_q <= ST_IDLE;
                out_q   <= '0;
            end else if (bus.mode && (state_q != ST_SCAN)) begin
                state_q <= ST_SCAN;
                idx_q   <= '0;
                cnt_q   <= '0;
                out_q   <= dec_out;
            end else if (bus.mode) begin
                idx_q   <= idx_d;
                cnt_q   <= cnt_d;
                wrap_q  <= wrap_d;
                out_q   <= dec_out;
            end else begin
                state_q <= ST_DIRECT;
                idx_q   <= sel_d;
                out_q   <= dec_out;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out       = out_q ^ OUT_POL;
    assign bus.idx       = idx_q;
    assign bus.scan_wrap = wrap_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: an 8-output/dwell-4 instance and a
// 6-output/dwell-2 instance share clock and reset.
module tb_decoder_scan;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_bad;

    decoder_scan_if #(.OUTS(8)) a8 ();
    decoder_scan_if #(.OUTS(6)) a6 ();

    decoder_scan #(.OUTS(8), .DWELL(4)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a8)
    );

    decoder_scan #(.OUTS(6), .DWELL(2)) u6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pol8(input logic [7:0] v);
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
        return {24'd0, ~v};
`else
        return {24'd0, v};
`endif
    endfunction

    function automatic logic [31:0] pol6(input logic [5:0] v);
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
        return {26'd0, ~v};
`else
        return {26'd0, v};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", tag, got, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_i;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        a8.en = 1'b0; a8.mode = 1'b0; a8.in = '0; a8.in_valid = 1'b0;
        a6.en = 1'b0; a6.mode = 1'b0; a6.in = '0; a6.in_valid = 1'b0;

        #3;
        check("rst out8",   32'(a8.out), pol8(8'h00));
        check("rst idx8",   32'(a8.idx), 32'd0);
        check("rst wrap8",  32'(a8.scan_wrap), 32'd0);
        check("rst err8",   32'(a8.err), 32'd0);
        check("rst out6",   32'(a6.out), pol6(6'h00));
        check("rst ready8", 32'(a8.in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Direct decode of 5, then of 0.
        a8.en = 1'b1; a8.mode = 1'b0; a8.in = 3'd5; a8.in_valid = 1'b1;
        #1;
        check("dir ready", 32'(a8.in_ready), 32'd1);
        tick();
        a8.in_valid = 1'b0;
        check("dir5 out", 32'(a8.out), pol8(8'b0010_0000));
        check("dir5 idx", 32'(a8.idx), 32'd5);
        check("dir5 err", 32'(a8.err), 32'd0);
        a8.in = 3'd0; a8.in_valid = 1'b1;
        tick();
        a8.in_valid = 1'b0;
        check("dir0 out", 32'(a8.out), pol8(8'h01));
        check("dir0 idx", 32'(a8.idx), 32'd0);

        // Scan on the 6-output instance: each index held two cycles, wrap at 5.
        a6.en = 1'b1; a6.mode = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            exp_i = (k / 2) % 6;
            check($sformatf("scan6 idx k%0d", k),   32'(a6.idx), 32'(exp_i));
            check($sformatf("scan6 out k%0d", k),   32'(a6.out), pol6(6'(1 << exp_i)));
            check($sformatf("scan6 wrap k%0d", k),  32'(a6.scan_wrap), (k == 12) ? 32'd1 : 32'd0);
            check($sformatf("scan6 ready k%0d", k), 32'(a6.in_ready), 32'd0);
        end

        // Back to direct resumes the stored selection (still 0).
        a6.mode = 1'b0;
        tick();
        check("ret6 idx",   32'(a6.idx), 32'd0);
        check("ret6 out",   32'(a6.out), pol6(6'b000001));
        check("ret6 ready", 32'(a6.in_ready), 32'd1);

        // Out-of-range index, then a legal one: err stays sticky.
        a6.in = 3'd7; a6.in_valid = 1'b1;
        tick();
        a6.in_valid = 1'b0;
        check("oor out", 32'(a6.out), pol6(6'b000000));
        check("oor idx", 32'(a6.idx), 32'd7);
        check("oor err", 32'(a6.err), 32'd1);
        a6.in = 3'd2; a6.in_valid = 1'b1;
        tick();
        a6.in_valid = 1'b0;
        check("in2 out", 32'(a6.out), pol6(6'b000100));
        check("in2 err", 32'(a6.err), 32'd1);

        // 8-output scan to index 3, drop enable, then restart.
        a8.mode = 1'b1;
        repeat (13) tick();
        check("scan8 idx3", 32'(a8.idx), 32'd3);
        check("scan8 out3", 32'(a8.out), pol8(8'h08));
        a8.en = 1'b0;
        tick();
        check("off out",   32'(a8.out), pol8(8'h00));
        check("off ready", 32'(a8.in_ready), 32'd1);
        check("off idx",   32'(a8.idx), 32'd3);
        a8.en = 1'b1; a8.mode = 1'b1;
        tick();
        check("restart idx",   32'(a8.idx), 32'd0);
        check("restart out",   32'(a8.out), pol8(8'h01));
        check("restart ready", 32'(a8.in_ready), 32'd0);

        // Asynchronous reset between edges, mid-dwell.
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst out8",  32'(a8.out), pol8(8'h00));
        check("arst idx8",  32'(a8.idx), 32'd0);
        check("arst wrap8", 32'(a8.scan_wrap), 32'd0);
        check("arst err6",  32'(a6.err), 32'd0);
        check("arst idx6",  32'(a6.idx), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
